// File: rtl/data_compress_pkg.sv
// Shared types and helpers for the data_compress_pack streaming packer.
//   popcount : number of set bits in a mask (up to MAXW bits)
//   therm    : thermometer mask with the low n bits set
//   cnt_t    : buffer occupancy type for the default N=8 build (0..2N)
package data_compress_pkg;
  localparam int N_DEF  = 8;
  localparam int DW_DEF = 32;
  localparam int CW_DEF = $clog2(2*N_DEF+1);
  localparam int MAXW   = 64;

  typedef logic [CW_DEF-1:0] cnt_t;

  function automatic int unsigned popcount(input logic [MAXW-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < MAXW; i++) c = c + 32'(v[i]);
    return c;
  endfunction

  function automatic logic [MAXW-1:0] therm(input int unsigned n);
    if (n >= MAXW) return '1;
    return (64'd1 << n) - 64'd1;
  endfunction
endpackage

// File: rtl/data_compress_pack_if.sv
// Stream bus of data_compress_pack: sparse input side (i_*) and dense
// output side (o_*). slave = the packer, master = producer/consumer side.
interface data_compress_pack_if #(
  parameter int DW = 32,
  parameter int N  = 8
);
  logic [N-1:0]  i_valid;
  logic [DW-1:0] i_data [N-1:0];
  logic          i_ready;
  logic          i_flush;
  logic [N-1:0]  o_valid;
  logic [DW-1:0] o_data [N-1:0];
  logic          o_last;
  logic          o_ready;

  modport slave  (input  i_valid, i_data, i_flush, o_ready,
                  output i_ready, o_valid, o_data, o_last);
  modport master (output i_valid, i_data, i_flush, o_ready,
                  input  i_ready, o_valid, o_data, o_last);
endinterface

// File: rtl/data_compress_lane.sv
// Combinational N-lane compactor: valid lanes are moved, in ascending lane
// order, to the lowest output slots; remaining slots are zero.
//   mask : per-lane valid
//   din  : lane data
//   dout : compacted data
//   cnt  : popcount(mask)
module data_compress_lane import data_compress_pkg::*; #(
  parameter int DW = 32,
  parameter int N  = 8,
  parameter int CW = $clog2(2*N+1)
) (
  input  logic [N-1:0]  mask,
  input  logic [DW-1:0] din  [N-1:0],
  output logic [DW-1:0] dout [N-1:0],
  output logic [CW-1:0] cnt
);
  localparam int IW = $clog2(N);

  logic [IW-1:0] wp;

  always_comb begin
    wp  = '0;
    cnt = '0;
    for (int j = 0; j < N; j++) dout[j] = '0;
    for (int i = 0; i < N; i++) begin
      if (mask[i]) begin
        dout[wp] = din[i];
        wp       = wp + 1'b1;
        cnt      = cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/data_compress_pack.sv
// Streaming lane packer: compacts sparse N-lane input beats into a 2N-entry
// buffer and emits dense N-wide beats, or a partial o_last beat on flush.
//   clk, rst_n : clock, async active-low reset
//   bus        : data_compress_pack_if.slave (i_valid/i_data/i_ready/i_flush,
//                o_valid/o_data/o_last/o_ready)
// Optional (DATA_COMPRESS_PACK_STAT_EN): o_elem_cnt = elements accepted,
// o_beat_cnt = output beats transferred; both wrap at 2^32.
module data_compress_pack import data_compress_pkg::*; #(
  parameter int DW = 32,
  parameter int N  = 8
) (
  input  logic clk,
  input  logic rst_n,
  data_compress_pack_if.slave bus
`ifdef DATA_COMPRESS_PACK_STAT_EN
  ,
  output logic [31:0] o_elem_cnt,
  output logic [31:0] o_beat_cnt
`endif
);
  localparam int CW = $clog2(2*N+1);
  localparam int BW = $clog2(2*N);

  logic [DW-1:0]   buf_q [2*N-1:0];
  logic [DW-1:0]   buf_n [2*N-1:0];
  logic [DW-1:0]   sh    [2*N-1:0];
  logic [CW-1:0]   cnt_q, cnt_n, cnt_ap, pop_amt, cpop;
  logic            flush_q, flush_n, pop, acc, irdy;
  logic [DW-1:0]   cdata [N-1:0];
  logic [N-1:0]    ov_q, ov_n;
  logic [DW-1:0]   od_q  [N-1:0];
  logic [DW-1:0]   od_n  [N-1:0];
  logic            ol_q, ol_n;
  logic [MAXW-1:0] therm_w;
  int              src;

  data_compress_lane #(.DW(DW), .N(N), .CW(CW)) u_lane (
    .mask (bus.i_valid),
    .din  (bus.i_data),
    .dout (cdata),
    .cnt  (cpop)
  );

  // A beat popped this cycle frees its space for the incoming beat.
  assign pop     = (|ov_q) && bus.o_ready;
  assign pop_amt = pop ? CW'(popcount(MAXW'(ov_q))) : '0;
  assign cnt_ap  = cnt_q - pop_amt;
  // Hold off input while draining so the flushed remainder is not topped up.
  assign irdy    = !flush_q && (cnt_ap <= CW'(N));
  assign acc     = (|bus.i_valid) && irdy;

  always_comb begin
    src = 0;
    for (int k = 0; k < 2*N; k++) begin
      src   = k + int'(pop_amt);
      sh[k] = (src < 2*N) ? buf_q[BW'(src)] : '0;
    end
    buf_n = sh;
    for (int j = 0; j < N; j++)
      if (acc && (CW'(j) < cpop)) buf_n[BW'(cnt_ap) + BW'(j)] = cdata[j];
    cnt_n = cnt_ap + (acc ? cpop : '0);

    // Flush is cleared by the o_last transfer or when nothing is left.
    flush_n = (flush_q && !(pop && ol_q)) || bus.i_flush;
    if (cnt_n == '0) flush_n = 1'b0;

    // Outputs are registered from the next state, giving one-cycle latency.
    therm_w = therm(32'(cnt_n));
    ov_n    = '0;
    ol_n    = 1'b0;
    for (int j = 0; j < N; j++) od_n[j] = '0;
    if (cnt_n >= CW'(N)) begin
      ov_n = '1;
      for (int j = 0; j < N; j++) od_n[j] = buf_n[j];
    end else if (flush_n) begin
      ov_n = therm_w[N-1:0];
      ol_n = 1'b1;
      for (int j = 0; j < N; j++) if (ov_n[j]) od_n[j] = buf_n[j];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      flush_q <= 1'b0;
      ov_q    <= '0;
      ol_q    <= 1'b0;
      for (int k = 0; k < 2*N; k++) buf_q[k] <= '0;
      for (int j = 0; j < N; j++)   od_q[j]  <= '0;
    end else begin
      cnt_q   <= cnt_n;
      flush_q <= flush_n;
      ov_q    <= ov_n;
      ol_q    <= ol_n;
      buf_q   <= buf_n;
      od_q    <= od_n;
    end
  end

  assign bus.i_ready = irdy;
  assign bus.o_valid = ov_q;
  assign bus.o_data  = od_q;
  assign bus.o_last  = ol_q;

`ifdef DATA_COMPRESS_PACK_STAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_elem_cnt <= '0;
      o_beat_cnt <= '0;
    end else begin
      if (acc) o_elem_cnt <= o_elem_cnt + 32'(cpop);
      if (pop) o_beat_cnt <= o_beat_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_data_compress_pack.sv
// Directed, table-driven bench for data_compress_pack (N=8, DW=32).
module tb_data_compress_pack;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_compress_pack_if #(.DW(32), .N(8)) bus ();

`ifdef DATA_COMPRESS_PACK_STAT_EN
  logic [31:0] elem_cnt, beat_cnt;
`endif

  data_compress_pack #(.DW(32), .N(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef DATA_COMPRESS_PACK_STAT_EN
    ,
    .o_elem_cnt (elem_cnt),
    .o_beat_cnt (beat_cnt)
`endif
  );

  typedef logic [7:0][31:0] lanes_t;

  typedef struct packed {
    logic [7:0]  iv;
    logic [31:0] base;
    logic        fl;
    logic        ordy;
    logic        eirdy;
    logic [7:0]  eov;
    lanes_t      eod;
    logic        eol;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic lanes_t seqd(input logic [31:0] b, input int n);
    lanes_t r;
    for (int i = 0; i < 8; i++) r[i] = (i < n) ? b + 32'(i) : 32'd0;
    return r;
  endfunction

  function automatic lanes_t odata();
    lanes_t r;
    for (int i = 0; i < 8; i++) r[i] = bus.o_data[i];
    return r;
  endfunction

  function automatic vec_t mk(input logic [7:0] iv, input logic [31:0] base,
                              input logic fl, input logic ordy, input logic eirdy,
                              input logic [7:0] eov, input lanes_t eod, input logic eol);
    vec_t v;
    v.iv = iv; v.base = base; v.fl = fl; v.ordy = ordy;
    v.eirdy = eirdy; v.eov = eov; v.eod = eod; v.eol = eol;
    return v;
  endfunction

  task automatic drive(input logic [7:0] iv, input logic [31:0] base, input logic fl, input logic ordy);
    bus.i_valid = iv;
    for (int i = 0; i < 8; i++) bus.i_data[i] = base + 32'(i);
    bus.i_flush = fl;
    bus.o_ready = ordy;
  endtask

  task automatic run_vec(input int k, input vec_t v);
    drive(v.iv, v.base, v.fl, v.ordy);
    #1;
    chk($sformatf("v%0d i_ready", k), 256'(bus.i_ready), 256'(v.eirdy));
    @(posedge clk); #1;
    bus.i_valid = '0;
    bus.i_flush = 1'b0;
    chk($sformatf("v%0d o_valid", k), 256'(bus.o_valid), 256'(v.eov));
    chk($sformatf("v%0d o_last", k), 256'(bus.o_last), 256'(v.eol));
    if (v.eov != 8'h00) chk($sformatf("v%0d o_data", k), odata(), v.eod);
  endtask

  initial begin
    lanes_t d4, d14;
    d4 = '0; d4[0] = 32'h100; d4[1] = 32'h102;
    d14 = seqd(32'h600, 6); d14[6] = 32'h700; d14[7] = 32'h701;

    // merge across cycles
    vecs[0]  = mk(8'h0F, 32'h0,   0, 1, 1, 8'h00, '0, 0);
    vecs[1]  = mk(8'hF0, 32'h0,   0, 1, 1, 8'hFF, seqd(32'h0, 8), 0);
    vecs[2]  = mk(8'h00, 32'h0,   0, 1, 1, 8'h00, '0, 0);
    // flush partial
    vecs[3]  = mk(8'h05, 32'h100, 0, 1, 1, 8'h00, '0, 0);
    vecs[4]  = mk(8'h00, 32'h0,   1, 1, 1, 8'h03, d4, 1);
    vecs[5]  = mk(8'h00, 32'h0,   0, 1, 0, 8'h00, '0, 0);
    vecs[6]  = mk(8'h00, 32'h0,   0, 1, 1, 8'h00, '0, 0);
    // backpressure: fill to 16, third beat refused, then drain in order
    vecs[7]  = mk(8'hFF, 32'h200, 0, 0, 1, 8'hFF, seqd(32'h200, 8), 0);
    vecs[8]  = mk(8'hFF, 32'h300, 0, 0, 1, 8'hFF, seqd(32'h200, 8), 0);
    vecs[9]  = mk(8'hFF, 32'h400, 0, 0, 0, 8'hFF, seqd(32'h200, 8), 0);
    vecs[10] = mk(8'h00, 32'h0,   0, 1, 1, 8'hFF, seqd(32'h300, 8), 0);
    vecs[11] = mk(8'h00, 32'h0,   0, 1, 1, 8'h00, '0, 0);
    // simultaneous push/pop
    vecs[12] = mk(8'hFF, 32'h500, 0, 1, 1, 8'hFF, seqd(32'h500, 8), 0);
    vecs[13] = mk(8'h3F, 32'h600, 0, 1, 1, 8'h00, '0, 0);
    vecs[14] = mk(8'h03, 32'h700, 0, 1, 1, 8'hFF, d14, 0);
    vecs[15] = mk(8'h00, 32'h0,   0, 1, 1, 8'h00, '0, 0);
    // flush with cnt>=N plus same-cycle beat: full beat first, then remainder
    vecs[16] = mk(8'hFF, 32'h800, 0, 0, 1, 8'hFF, seqd(32'h800, 8), 0);
    vecs[17] = mk(8'h07, 32'h900, 1, 0, 1, 8'hFF, seqd(32'h800, 8), 0);
    vecs[18] = mk(8'h00, 32'h0,   0, 1, 0, 8'h07, seqd(32'h900, 3), 1);
    vecs[19] = mk(8'h00, 32'h0,   0, 1, 0, 8'h00, '0, 0);
    // flush on empty buffer: no beat, no lingering flush
    vecs[20] = mk(8'h00, 32'h0,   1, 1, 1, 8'h00, '0, 0);
    vecs[21] = mk(8'h00, 32'h0,   0, 1, 1, 8'h00, '0, 0);

    drive(8'h00, 32'h0, 0, 0);
    #2;
    chk("reset o_valid", 256'(bus.o_valid), 256'(8'h00));
    chk("reset i_ready", 256'(bus.i_ready), 256'(1'b1));
    chk("reset o_last",  256'(bus.o_last),  256'(1'b0));
    chk("reset o_data",  odata(), '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post-reset o_valid", 256'(bus.o_valid), 256'(8'h00));

    for (int k = 0; k < NV; k++) run_vec(k, vecs[k]);

    // reset mid-operation with cnt=5 and a pending flush
    drive(8'h1F, 32'hA00, 0, 0);
    @(posedge clk); #1;
    drive(8'h00, 32'h0, 1, 0);
    @(posedge clk); #1;
    bus.i_flush = 1'b0;
    chk("mid pre o_valid", 256'(bus.o_valid), 256'(8'h1F));
    chk("mid pre o_last",  256'(bus.o_last),  256'(1'b1));
    rst_n = 1'b0;
    #1;
    chk("mid rst o_valid", 256'(bus.o_valid), 256'(8'h00));
    chk("mid rst o_last",  256'(bus.o_last),  256'(1'b0));
    chk("mid rst o_data",  odata(), '0);
    chk("mid rst i_ready", 256'(bus.i_ready), 256'(1'b1));
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.o_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("mid after o_valid", 256'(bus.o_valid), 256'(8'h00));
    chk("mid after i_ready", 256'(bus.i_ready), 256'(1'b1));
    drive(8'hFF, 32'hB00, 0, 1);
    @(posedge clk); #1;
    bus.i_valid = '0;
    chk("mid fresh o_valid", 256'(bus.o_valid), 256'(8'hFF));
    chk("mid fresh o_data",  odata(), seqd(32'hB00, 8));
    chk("mid fresh o_last",  256'(bus.o_last), 256'(1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
